// File: rtl/hack_io_pkg.sv
// rtl/hack_io_pkg.sv - shared constants, register decode and defaults for the Hack I/O controller
package hack_io_pkg;

  localparam int DEF_WORD_WIDTH    = 16;
  localparam int DEF_ADDRESS_WIDTH = 15;
  localparam int DEF_BASE_ADDRESS  = 'h6000;
  localparam int DEF_GPIO_PORTS    = 2;
  localparam int DEF_KBD_DEPTH     = 4;
  localparam int DEF_WAIT_CLOCKS   = 2;

  localparam int unsigned OFS_KBD_DATA  = 0;
  localparam int unsigned OFS_KBD_CTRL  = 1;
  localparam int unsigned OFS_GPIO_BASE = 2;

  typedef enum logic [2:0] {
    RK_NONE,
    RK_KBD_DATA,
    RK_KBD_CTRL,
    RK_GPIO_OUT,
    RK_GPIO_DIR
  } reg_kind_e;

  function automatic int kbd_ovf_bit(input int word_width);
    return word_width - 1;
  endfunction

  // GPIO registers come in OUT/DIR pairs, so even offsets are OUT and odd are DIR.
  function automatic reg_kind_e decode_offset(input int unsigned ofs, input int unsigned ports);
    if (ofs == OFS_KBD_DATA) return RK_KBD_DATA;
    if (ofs == OFS_KBD_CTRL) return RK_KBD_CTRL;
    if (ofs < OFS_GPIO_BASE + 2 * ports) return (ofs % 2 == 0) ? RK_GPIO_OUT : RK_GPIO_DIR;
    return RK_NONE;
  endfunction

endpackage

// File: rtl/hack_io_fifo.sv
// rtl/hack_io_fifo.sv - keyboard code FIFO; a pop makes room for a push in the same cycle when full
module hack_io_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/hack_io_ctrl.sv
// rtl/hack_io_ctrl.sv - Hack CPU memory-mapped I/O: keyboard FIFO, GPIO ports and CPU reset sequencer
// Optional HACK_IO_GPIO_SYNC_EN: two-flop synchroniser on gpio_in (2-cycle read latency).
module hack_io_ctrl
  import hack_io_pkg::*;
#(
  parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int BASE_ADDRESS  = DEF_BASE_ADDRESS,
  parameter int GPIO_PORTS    = DEF_GPIO_PORTS,
  parameter int KBD_DEPTH     = DEF_KBD_DEPTH,
  parameter int WAIT_CLOCKS   = DEF_WAIT_CLOCKS
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             hack_clk_strobe,
  input  logic                             hack_external_reset,
  input  logic [ADDRESS_WIDTH-1:0]         hack_addressM,
  input  logic                             hack_writeM,
  input  logic [WORD_WIDTH-1:0]            hack_outM,
  output logic                             io_hit,
  output logic [WORD_WIDTH-1:0]            io_rdata,
  output logic                             hack_reset,
  input  logic                             kbd_valid,
  input  logic [WORD_WIDTH-1:0]            kbd_data,
  output logic                             kbd_ready,
  output logic [GPIO_PORTS*WORD_WIDTH-1:0] gpio_out,
  output logic [GPIO_PORTS*WORD_WIDTH-1:0] gpio_oe,
  input  logic [GPIO_PORTS*WORD_WIDTH-1:0] gpio_in
);
  localparam int CW      = $clog2(KBD_DEPTH) + 1;
  localparam int GW      = GPIO_PORTS * WORD_WIDTH;
  localparam int OVF_BIT = kbd_ovf_bit(WORD_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] BASE_A = ADDRESS_WIDTH'(BASE_ADDRESS);

  logic [ADDRESS_WIDTH-1:0] offset;
  reg_kind_e                kind;
  logic                     reg_wr, kbd_pop, kbd_push;
  logic                     fifo_full, fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic [WORD_WIDTH-1:0]    fifo_head;
  logic                     ovf_q, ovf_d;
  logic [3:0]               wait_q, wait_d;
  logic [GW-1:0]            out_q, dir_q, in_s;

  assign offset = hack_addressM - BASE_A;

  always_comb begin
    kind = RK_NONE;
    if (hack_addressM >= BASE_A) kind = decode_offset(32'(offset), GPIO_PORTS);
  end

  assign io_hit    = (kind != RK_NONE);
  assign reg_wr    = hack_writeM && hack_clk_strobe;
  assign kbd_pop   = reg_wr && (kind == RK_KBD_CTRL);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the offered code.
  assign kbd_ready = !fifo_full || kbd_pop;
  assign kbd_push  = kbd_valid && kbd_ready && (kbd_data != '0);

  hack_io_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (KBD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (kbd_push),
    .pop     (kbd_pop),
    .wdata   (kbd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (fifo_head)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (kbd_valid && !kbd_ready) ovf_d = 1'b1;
    else if (kbd_pop)            ovf_d = 1'b0;

    wait_d = wait_q;
    if (hack_external_reset)                   wait_d = 4'(WAIT_CLOCKS);
    else if (hack_clk_strobe && wait_q != '0)  wait_d = wait_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q  <= 1'b0;
      wait_q <= 4'(WAIT_CLOCKS);
      out_q  <= '0;
      dir_q  <= '0;
    end else begin
      ovf_q  <= ovf_d;
      wait_q <= wait_d;
      if (reg_wr && io_hit) begin
        for (int i = 0; i < GPIO_PORTS; i++) begin
          if (offset == ADDRESS_WIDTH'(OFS_GPIO_BASE + 2 * i))
            out_q[i*WORD_WIDTH +: WORD_WIDTH] <= hack_outM;
          if (offset == ADDRESS_WIDTH'(OFS_GPIO_BASE + 2 * i + 1))
            dir_q[i*WORD_WIDTH +: WORD_WIDTH] <= hack_outM;
        end
      end
    end
  end

`ifdef HACK_IO_GPIO_SYNC_EN
  logic [GW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = gpio_in;
`endif

  always_comb begin
    io_rdata = '0;
    case (kind)
      RK_KBD_DATA: io_rdata = fifo_empty ? '0 : fifo_head;
      RK_KBD_CTRL: begin
        io_rdata[OVF_BIT]  = ovf_q;
        io_rdata[CW-1:0]   = fifo_count;
      end
      RK_GPIO_OUT, RK_GPIO_DIR: begin
        for (int i = 0; i < GPIO_PORTS; i++) begin
          if (offset == ADDRESS_WIDTH'(OFS_GPIO_BASE + 2 * i))
            io_rdata = (out_q[i*WORD_WIDTH +: WORD_WIDTH] & dir_q[i*WORD_WIDTH +: WORD_WIDTH])
                     | (in_s[i*WORD_WIDTH +: WORD_WIDTH] & ~dir_q[i*WORD_WIDTH +: WORD_WIDTH]);
          if (offset == ADDRESS_WIDTH'(OFS_GPIO_BASE + 2 * i + 1))
            io_rdata = dir_q[i*WORD_WIDTH +: WORD_WIDTH];
        end
      end
      default: io_rdata = '0;
    endcase
  end

  assign hack_reset = !reset_n || hack_external_reset || (wait_q != '0);
  assign gpio_out   = out_q;
  assign gpio_oe    = dir_q;

endmodule

// File: tb/tb_hack_io_ctrl.sv
// tb/tb_hack_io_ctrl.sv - directed self-checking bench for hack_io_ctrl at default parameters
module tb_hack_io_ctrl;
  localparam int WW = 16, AW = 15, BASE = 'h6000, GP = 2;

  logic              clk = 1'b0;
  logic              reset_n, hack_clk_strobe, hack_external_reset, hack_writeM;
  logic [AW-1:0]     hack_addressM;
  logic [WW-1:0]     hack_outM, io_rdata, kbd_data;
  logic              io_hit, hack_reset, kbd_valid, kbd_ready;
  logic [GP*WW-1:0]  gpio_out, gpio_oe, gpio_in;

  int n_vec = 0;
  int n_bad = 0;

  hack_io_ctrl dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .hack_clk_strobe     (hack_clk_strobe),
    .hack_external_reset (hack_external_reset),
    .hack_addressM       (hack_addressM),
    .hack_writeM         (hack_writeM),
    .hack_outM           (hack_outM),
    .io_hit              (io_hit),
    .io_rdata            (io_rdata),
    .hack_reset          (hack_reset),
    .kbd_valid           (kbd_valid),
    .kbd_data            (kbd_data),
    .kbd_ready           (kbd_ready),
    .gpio_out            (gpio_out),
    .gpio_oe             (gpio_oe),
    .gpio_in             (gpio_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input int ofs, input logic [31:0] exp);
    hack_addressM = AW'(BASE + ofs);
    #1;
    chk(tag, {16'h0, io_rdata}, exp);
  endtask

  task automatic wr(input int ofs, input logic [WW-1:0] data);
    hack_addressM   = AW'(BASE + ofs);
    hack_outM       = data;
    hack_writeM     = 1'b1;
    hack_clk_strobe = 1'b1;
    cyc();
    hack_writeM     = 1'b0;
    hack_clk_strobe = 1'b0;
  endtask

  task automatic strobe_pulse();
    hack_clk_strobe = 1'b1;
    cyc();
    hack_clk_strobe = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic push(input logic [WW-1:0] code);
    kbd_valid = 1'b1;
    kbd_data  = code;
    cyc();
    kbd_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; hack_clk_strobe = 1'b0; hack_external_reset = 1'b0;
    hack_writeM = 1'b0; hack_addressM = AW'(BASE); hack_outM = '0;
    kbd_valid = 1'b0; kbd_data = '0; gpio_in = '0;
    repeat (2) cyc();
    chk("rst_hack_reset", hack_reset, 1);
    chk("rst_kbd_ready", kbd_ready, 1);
    chk("rst_gpio_oe", gpio_oe, 0);
    chk("rst_gpio_out", gpio_out, 0);
    chk_rd("rst_kbd_ctrl", 1, 0);
    chk_rd("rst_kbd_data", 0, 0);

    reset_n = 1'b1;
    cyc();
    chk("seq_before_strobe", hack_reset, 1);
    strobe_pulse();
    chk("seq_after_strobe1", hack_reset, 1);
    strobe_pulse();
    chk("seq_after_strobe2", hack_reset, 0);

    push(16'h61); push(16'h62);
    chk_rd("kbd_head_61", 0, 'h61);
    chk_rd("kbd_count_2", 1, 'h2);
    wr(1, 16'h0);
    chk_rd("kbd_head_62", 0, 'h62);
    chk_rd("kbd_count_1", 1, 'h1);
    wr(0, 16'h55);
    chk_rd("kbd_data_wr_ignored", 1, 'h1);
    wr(1, 16'h0);
    chk_rd("kbd_empty_data", 0, 0);
    chk_rd("kbd_empty_ctrl", 1, 0);
    push(16'h0);
    wr(1, 16'h0);
    chk_rd("kbd_zero_discard_pop_empty", 1, 0);

    for (int c = 1; c <= 4; c++) push(WW'(c));
    chk("kbd_ready_full", kbd_ready, 0);
    push(16'h5);
    chk_rd("kbd_overflow_ctrl", 1, 'h8004);
    chk_rd("kbd_overflow_head", 0, 'h1);
    wr(1, 16'h0);
    chk_rd("kbd_pop_clears_ovf", 1, 'h0003);
    chk_rd("kbd_head_after_pop", 0, 'h2);
    push(16'h6);
    chk_rd("kbd_refull", 1, 'h0004);
    hack_addressM = AW'(BASE + 1); hack_writeM = 1'b1; hack_clk_strobe = 1'b1;
    kbd_valid = 1'b1; kbd_data = 16'h7;
    #1;
    chk("kbd_ready_full_pop", kbd_ready, 1);
    cyc();
    hack_writeM = 1'b0; hack_clk_strobe = 1'b0; kbd_valid = 1'b0;
    chk_rd("kbd_push_pop_full_ctrl", 1, 'h0004);
    chk_rd("kbd_push_pop_full_head", 0, 'h3);

    wr(5, 16'h00FF);
    wr(4, 16'h1234);
    gpio_in = {16'hAB00, 16'h5A5A};
`ifdef HACK_IO_GPIO_SYNC_EN
    repeat (2) cyc();
`endif
    chk("gpio_out1", gpio_out[31:16], 'h1234);
    chk("gpio_oe", gpio_oe, 'h00FF_0000);
    chk_rd("gpio_rd_out1", 4, 'hAB34);
    chk_rd("gpio_rd_dir1", 5, 'h00FF);
    wr(2, 16'hFFFF);
    chk_rd("gpio_rd_out0_input", 2, 'h5A5A);
    chk("gpio_out_both", gpio_out, 'h1234_FFFF);
    hack_addressM = AW'(BASE + 4); hack_outM = '0; hack_writeM = 1'b1;
    cyc();
    hack_writeM = 1'b0;
    chk("gpio_no_strobe_no_write", gpio_out, 'h1234_FFFF);

    hack_external_reset = 1'b1;
    #1;
    chk("ext_reset_comb", hack_reset, 1);
    cyc();
    hack_external_reset = 1'b0;
    strobe_pulse();
    chk("ext_mid_count", hack_reset, 1);
    hack_external_reset = 1'b1;
    cyc();
    hack_external_reset = 1'b0;
    strobe_pulse();
    chk("ext_reload_strobe1", hack_reset, 1);
    strobe_pulse();
    chk("ext_reload_strobe2", hack_reset, 0);
    chk("ext_gpio_out_kept", gpio_out, 'h1234_FFFF);
    chk("ext_gpio_oe_kept", gpio_oe, 'h00FF_0000);
    chk_rd("ext_kbd_ctrl_kept", 1, 'h0004);
    chk_rd("ext_kbd_head_kept", 0, 'h3);

    hack_addressM = AW'(BASE + 6);
    #1;
    chk("oow_hit", io_hit, 0);
    chk("oow_rdata", io_rdata, 0);
    wr(6, 16'hFFFF);
    chk("oow_gpio_out", gpio_out, 'h1234_FFFF);
    chk("oow_gpio_oe", gpio_oe, 'h00FF_0000);
    chk_rd("oow_kbd_ctrl", 1, 'h0004);
    hack_addressM = AW'(BASE + 5);
    #1;
    chk("last_reg_hit", io_hit, 1);
    hack_addressM = AW'(BASE - 1);
    #1;
    chk("below_base_hit", io_hit, 0);
    chk("below_base_rdata", io_rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hack_io_ctrl.md
HACK_IO_CTRL -- requirements
Module: hack_io_ctrl

Interface
REQ-001 Parameter WORD_WIDTH, 16, data word width of the Hack bus, keyboard codes and GPIO ports; SHALL be honoured throughout.
REQ-002 Parameter ADDRESS_WIDTH, 15, Hack addressM width; SHALL be honoured throughout.
REQ-003 Parameter BASE_ADDRESS, 'h6000, first I/O address (keyboard); SHALL be honoured throughout.
REQ-004 Parameter GPIO_PORTS, 2, number of GPIO ports, 1..8; SHALL be honoured throughout.
REQ-005 Parameter KBD_DEPTH, 4, keyboard FIFO depth, power of two >=2; SHALL be honoured throughout.
REQ-006 Parameter WAIT_CLOCKS, 2, Hack strobes held in reset after release, 1..15; SHALL be honoured throughout.
REQ-007 Ports SHALL be as listed, clock and reset first:
 clk  in  1  single clock.
 reset_n  in  1  synchronous, active-low reset.
 hack_clk_strobe  in  1  one-cycle pulse marking a Hack CPU cycle boundary.
 hack_external_reset  in  1  external CPU reset request.
 hack_addressM  in  ADDRESS_WIDTH  CPU address.
 hack_writeM  in  1  CPU write enable.
 hack_outM  in  WORD_WIDTH  CPU write data.
 io_hit  out  1  address in I/O window.
 io_rdata  out  WORD_WIDTH  read data for inM mux.
 hack_reset  out  1  CPU reset.
 kbd_valid  in  1  key code offered.
 kbd_data  in  WORD_WIDTH  key code.
 kbd_ready  out  1  FIFO not full.
 gpio_out  out  GPIO_PORTS*WORD_WIDTH  port output values.
 gpio_oe  out  GPIO_PORTS*WORD_WIDTH  per-bit output enables.
 gpio_in  in  GPIO_PORTS*WORD_WIDTH  pad inputs.

Function
REQ-008 Register map (offset from BASE_ADDRESS): 0 KBD_DATA, 1 KBD_CTRL, 2+2i GPIO_OUT[i], 3+2i GPIO_DIR[i]; io_hit SHALL be high combinationally for offsets 0..1+2*GPIO_PORTS.
REQ-009 KBD_DATA read SHALL return the FIFO head, or 0 when empty; reads SHALL NOT pop; writes are ignored.
REQ-010 KBD_CTRL read SHALL return {overflow flag at bit WORD_WIDTH-1, count in the low bits}; a write qualified by hack_clk_strobe SHALL pop one entry (no-op when empty) and clear the overflow flag.
REQ-011 Push SHALL occur on any cycle with kbd_valid && kbd_ready; kbd_data==0 SHALL be discarded.
REQ-012 kbd_valid while full SHALL drop the code and set the sticky overflow flag.
REQ-013 Simultaneous push and pop while full SHALL perform both, with count unchanged and no overflow.
REQ-014 FIFO pointers SHALL wrap modulo KBD_DEPTH; the count SHALL be $clog2(KBD_DEPTH)+1 bits.
REQ-015 A GPIO_OUT/GPIO_DIR write SHALL take effect on the cycle hack_writeM && hack_clk_strobe && address match; gpio_oe SHALL equal GPIO_DIR.
REQ-016 GPIO_OUT[i] read SHALL return (out & dir) | (in_s & ~dir), where in_s is the per-REQ-022 input; GPIO_DIR read SHALL return dir.
REQ-017 io_rdata SHALL be 0 when io_hit is low; latency is 0 cycles, combinational from address.
REQ-018 Reset sequencer: wait counter loaded with WAIT_CLOCKS on reset or hack_external_reset; otherwise it SHALL decrement on each hack_clk_strobe while nonzero.
REQ-019 hack_reset = !reset_n || hack_external_reset || counter!=0.
REQ-020 hack_external_reset asserted mid-count SHALL reload the counter; GPIO and FIFO SHALL NOT be cleared by it.

Reset
REQ-021 On reset_n low at a clk edge: FIFO empty, overflow 0, kbd_ready 1, gpio_out 0, gpio_oe 0, counter WAIT_CLOCKS, hack_reset 1; synchroniser flops 0.

Configuration
REQ-022 With HACK_IO_GPIO_SYNC_EN defined, gpio_in SHALL pass through a two-flop synchroniser (2-cycle latency to read data); without it, in_s = gpio_in directly (0 latency).

Structure
REQ-023 Package hack_io_pkg SHALL hold register offsets, KBD_CTRL overflow bit index and the default parameter constants.
REQ-024 The FIFO SHALL be a sub-module hack_io_fifo (WIDTH, DEPTH; push, pop, full, empty, count, head).

Verification
REQ-025 Reset released, strobe every 4 clk -> hack_reset falls after the 2nd strobe; gpio_oe==0, kbd_ready==1.
REQ-026 Push 'h61,'h62 -> KBD_DATA reads 'h61, KBD_CTRL reads 2; write KBD_CTRL -> KBD_DATA reads 'h62, count 1.
REQ-027 Push 5 codes into depth 4 -> 5th dropped, KBD_CTRL reads 'h8004; pop -> 'h0003.
REQ-028 Write GPIO_DIR[1]='h00FF, GPIO_OUT[1]='h1234, gpio_in[1]='hAB00 -> gpio_out[1]='h1234, read GPIO_OUT[1] returns 'hAB34 (2 clk later when HACK_IO_GPIO_SYNC_EN is defined).
REQ-029 hack_external_reset pulse mid-run -> hack_reset high for 2 further strobes; GPIO and FIFO contents unchanged.
REQ-030 Address BASE_ADDRESS+6 with GPIO_PORTS=2 -> io_hit 0, io_rdata 0; a write there changes nothing.
